// File: rtl/decoder_nxm_reg.sv
// Registered N-to-M decoder with a valid/ready input handshake,
// selectable output encoding and a programmable output hold timer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         block enable; low clears the output on the next edge
//   mode       00 one-hot, 01 thermometer, 10 active-low one-hot, 11 binary
//   hold_cyc   0 = level output, N>0 = output held exactly N cycles
//   in_valid   input code valid
//   in_ready   block can accept a code (combinational)
//   in         code to decode
//   out        registered decoded pattern
//   out_valid  out holds a live pattern
//   err        one-cycle pulse after an out-of-range accept
module decoder_nxm_reg #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 8,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [HOLD_W-1:0] hold_cyc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic              err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // OUT_W may equal 2**IN_W, so the limit needs one extra bit.
    localparam logic [IN_W:0] LIMIT = (IN_W + 1)'(OUT_W);

    state_t              state;
    state_t              state_nxt;
    logic [HOLD_W-1:0]   cnt;
    logic [HOLD_W-1:0]   cnt_nxt;
    logic [OUT_W-1:0]    out_nxt;
    logic                out_valid_nxt;
    logic                err_nxt;

    logic [IN_W:0]       code_ext;
    logic                in_range;
    logic                bad_code;
    logic                accept;
    logic [OUT_W-1:0]    onehot;
    logic [OUT_W-1:0]    thermo;
    logic [OUT_W-1:0]    pattern;

    assign code_ext = {1'b0, in};
    assign in_range = code_ext < LIMIT;
    assign bad_code = (mode != 2'b11) && !in_range;

    // In pulse mode the counter is non-zero for the whole ACTIVE
    // period, so a zero counter while ACTIVE means level mode.
    assign in_ready = en && ((state == IDLE) || (cnt == '0));
    assign accept   = in_valid && in_ready;

    always_comb begin
        onehot = '0;
        thermo = '0;
        for (int j = 0; j < OUT_W; j++) begin
            onehot[j] = (code_ext == (IN_W + 1)'(j));
            thermo[j] = ((IN_W + 1)'(j) <= code_ext);
        end
    end

    always_comb begin
        pattern = '0;
        unique case (mode)
            2'b00: pattern = onehot;
            2'b01: pattern = thermo;
            2'b10: pattern = ~onehot;
            2'b11: pattern = OUT_W'(in);
            default: pattern = '0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        out_nxt       = out;
        out_valid_nxt = out_valid;
        err_nxt       = 1'b0;

        if (!en) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            out_nxt       = '0;
            out_valid_nxt = 1'b0;
        end else if (accept) begin
            if (bad_code) begin
                state_nxt     = IDLE;
                cnt_nxt       = '0;
                out_nxt       = '0;
                out_valid_nxt = 1'b0;
                err_nxt       = 1'b1;
            end else begin
                state_nxt     = ACTIVE;
                cnt_nxt       = hold_cyc;
                out_nxt       = pattern;
                out_valid_nxt = 1'b1;
            end
        end else if ((state == ACTIVE) && (cnt != '0)) begin
            if (cnt == HOLD_W'(1)) begin
                state_nxt     = IDLE;
                cnt_nxt       = '0;
                out_nxt       = '0;
                out_valid_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_nxm_reg.sv
// Directed self-checking bench for decoder_nxm_reg.
// Covers an OUT_W=8 instance and an OUT_W=6 range-check instance.
module tb_decoder_nxm_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] hold_cyc = 4'd0;
    logic [2:0] code = 3'd0;
    logic       v8 = 1'b0;
    logic       v6 = 1'b0;

    logic       rdy8, ov8, err8;
    logic [7:0] out8;
    logic       rdy6, ov6, err6;
    logic [5:0] out6;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_nxm_reg #(.IN_W(3), .OUT_W(8), .HOLD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .hold_cyc(hold_cyc), .in_valid(v8), .in_ready(rdy8),
        .in(code), .out(out8), .out_valid(ov8), .err(err8)
    );

    decoder_nxm_reg #(.IN_W(3), .OUT_W(6), .HOLD_W(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .hold_cyc(hold_cyc), .in_valid(v6), .in_ready(rdy6),
        .in(code), .out(out6), .out_valid(ov6), .err(err6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (out8 !== 8'h00 || ov8 !== 1'b0 || err8 !== 1'b0) begin
            failures++;
            $display("FAIL reset out=%h ov=%b err=%b exp 00/0/0",
                     out8, ov8, err8);
        end
        checks++;
        if (out6 !== 6'h00 || ov6 !== 1'b0 || err6 !== 1'b0) begin
            failures++;
            $display("FAIL reset6 out=%h ov=%b err=%b exp 00/0/0",
                     out6, ov6, err6);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready rdy=%b exp 1", rdy8);
        end
    endtask

    task automatic test_level();
        mode = 2'b00; hold_cyc = 4'd0; code = 3'd5; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        checks++;
        if (out8 !== 8'h20 || ov8 !== 1'b1 || rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL level5 out=%h ov=%b rdy=%b exp 20/1/1",
                     out8, ov8, rdy8);
        end
        repeat (4) tick();
        checks++;
        if (out8 !== 8'h20 || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL level_hold out=%h ov=%b exp 20/1", out8, ov8);
        end
    endtask

    task automatic test_back_to_back();
        mode = 2'b01; code = 3'd3; v8 = 1'b1;
        tick();
        checks++;
        if (out8 !== 8'h0F || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_thermo3 out=%h ov=%b exp 0f/1", out8, ov8);
        end
        mode = 2'b10; code = 3'd0;
        tick();
        v8 = 1'b0;
        checks++;
        if (out8 !== 8'hFE || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_nhot0 out=%h ov=%b exp fe/1", out8, ov8);
        end
        tick();
        checks++;
        if (out8 !== 8'hFE) begin
            failures++;
            $display("FAIL b2b_held out=%h exp fe", out8);
        end
    endtask

    task automatic test_pulse();
        mode = 2'b00; hold_cyc = 4'd3; code = 3'd2; v8 = 1'b1;
        tick();
        code = 3'd6;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (out8 !== 8'h04 || ov8 !== 1'b1 || rdy8 !== 1'b0) begin
                failures++;
                $display("FAIL pulse_c%0d out=%h ov=%b rdy=%b exp 04/1/0",
                         c, out8, ov8, rdy8);
            end
            tick();
        end
        checks++;
        if (out8 !== 8'h00 || ov8 !== 1'b0 || rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL pulse_end out=%h ov=%b rdy=%b exp 00/0/1",
                     out8, ov8, rdy8);
        end
        tick();
        v8 = 1'b0;
        mode = 2'b11;
        hold_cyc = 4'd0;
        checks++;
        if (out8 !== 8'h40 || ov8 !== 1'b1 || rdy8 !== 1'b0) begin
            failures++;
            $display("FAIL pulse_reacc out=%h ov=%b rdy=%b exp 40/1/0",
                     out8, ov8, rdy8);
        end
        tick();
        tick();
        checks++;
        if (out8 !== 8'h40 || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL pulse_sampled out=%h ov=%b exp 40/1", out8, ov8);
        end
        tick();
        checks++;
        if (out8 !== 8'h00 || ov8 !== 1'b0) begin
            failures++;
            $display("FAIL pulse2_end out=%h ov=%b exp 00/0", out8, ov8);
        end
    endtask

    task automatic test_range();
        hold_cyc = 4'd0;
        mode = 2'b00; code = 3'd7; v6 = 1'b1;
        tick();
        v6 = 1'b0;
        checks++;
        if (err6 !== 1'b1 || out6 !== 6'h00 || ov6 !== 1'b0) begin
            failures++;
            $display("FAIL range7 err=%b out=%h ov=%b exp 1/00/0",
                     err6, out6, ov6);
        end
        tick();
        checks++;
        if (err6 !== 1'b0) begin
            failures++;
            $display("FAIL range_pulse err=%b exp 0", err6);
        end
        mode = 2'b11; v6 = 1'b1;
        tick();
        v6 = 1'b0;
        checks++;
        if (out6 !== 6'b000111 || err6 !== 1'b0 || ov6 !== 1'b1) begin
            failures++;
            $display("FAIL range_bin out=%b err=%b ov=%b exp 000111/0/1",
                     out6, err6, ov6);
        end
        mode = 2'b00; code = 3'd5; v6 = 1'b1;
        tick();
        v6 = 1'b0;
        checks++;
        if (out6 !== 6'b100000 || err6 !== 1'b0) begin
            failures++;
            $display("FAIL range_edge5 out=%b err=%b exp 100000/0",
                     out6, err6);
        end
        mode = 2'b01; code = 3'd6; v6 = 1'b1;
        tick();
        v6 = 1'b0;
        checks++;
        if (err6 !== 1'b1 || out6 !== 6'h00 || ov6 !== 1'b0) begin
            failures++;
            $display("FAIL range_th6 err=%b out=%h ov=%b exp 1/00/0",
                     err6, out6, ov6);
        end
        checks++;
        if (err8 !== 1'b0) begin
            failures++;
            $display("FAIL range_err8 err=%b exp 0", err8);
        end
    endtask

    task automatic test_en_drop();
        mode = 2'b00; hold_cyc = 4'd8; code = 3'd1; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        checks++;
        if (out8 !== 8'h02 || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL en_start out=%h ov=%b exp 02/1", out8, ov8);
        end
        tick();
        tick();
        en = 1'b0;
        #1;
        checks++;
        if (rdy8 !== 1'b0 || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL en_low_rdy rdy=%b ov=%b exp 0/1", rdy8, ov8);
        end
        v8 = 1'b1;
        tick();
        checks++;
        if (out8 !== 8'h00 || ov8 !== 1'b0 || rdy8 !== 1'b0) begin
            failures++;
            $display("FAIL en_drop out=%h ov=%b rdy=%b exp 00/0/0",
                     out8, ov8, rdy8);
        end
        tick();
        checks++;
        if (out8 !== 8'h00 || ov8 !== 1'b0) begin
            failures++;
            $display("FAIL en_ignore out=%h ov=%b exp 00/0", out8, ov8);
        end
        v8 = 1'b0;
        en = 1'b1;
        #1;
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL en_back rdy=%b exp 1", rdy8);
        end
    endtask

    task automatic test_async_reset();
        mode = 2'b00; hold_cyc = 4'd8; code = 3'd4; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        tick();
        checks++;
        if (out8 !== 8'h10 || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL ar_start out=%h ov=%b exp 10/1", out8, ov8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out8 !== 8'h00 || ov8 !== 1'b0) begin
            failures++;
            $display("FAIL ar_immediate out=%h ov=%b exp 00/0", out8, ov8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (out8 !== 8'h00 || rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL ar_after out=%h rdy=%b exp 00/1", out8, rdy8);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        logic [8:0] th;
        hold_cyc = 4'd0;
        for (int m = 0; m < 4; m++) begin
            for (int k = 0; k < 8; k++) begin
                mode = 2'(m);
                code = 3'(k);
                v8 = 1'b1;
                tick();
                th = (9'd2 << k) - 9'd1;
                case (m)
                    0: exp = 8'd1 << k;
                    1: exp = th[7:0];
                    2: exp = ~(8'd1 << k);
                    default: exp = 8'(k);
                endcase
                checks++;
                if (out8 !== exp || ov8 !== 1'b1 || err8 !== 1'b0) begin
                    failures++;
                    $display("FAIL sweep m%0d k%0d out=%h ov=%b err=%b exp %h",
                             m, k, out8, ov8, err8, exp);
                end
            end
        end
        v8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_level();
        test_back_to_back();
        test_pulse();
        test_range();
        test_en_drop();
        test_async_reset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
